// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decoded instruction fields in, registered EX fields out.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_shamt;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [3:0]    id_alu_op;
    logic          id_alu_src_imm;
    logic          id_is_shift;
    logic          id_shift_var;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_reg_write;
    logic          id_mem_to_reg;

    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_alu_a;
    logic [DW-1:0] ex_alu_b;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic [3:0]    ex_alu_op;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_reg_write;
    logic          ex_mem_to_reg;

    modport master (
        output id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_rs, id_rt, id_rd, id_alu_op, id_alu_src_imm, id_is_shift,
               id_shift_var, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
        input  ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_store_data, ex_rd,
               ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg
    );

    modport slave (
        input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_rs, id_rt, id_rd, id_alu_op, id_alu_src_imm, id_is_shift,
               id_shift_var, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
        output ex_valid, ex_pc, ex_alu_a, ex_alu_b, ex_store_data, ex_rd,
               ex_alu_op, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand formation and load-use bubble insertion.
// Load-use detection is compiled in only when HAZARD_DETECT_EN is defined.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_stage_if.slave bus,
    input  logic        stall_ext,
    input  logic        flush,
    output logic        hazard_stall,
    output logic [15:0] hazard_cnt
);
`ifdef HAZARD_DETECT_EN
    localparam bit HD_EN = 1'b1;
`else
    localparam bit HD_EN = 1'b0;
`endif

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] alu_a;
        logic [DW-1:0] alu_b;
        logic [DW-1:0] store_data;
        logic [RW-1:0] rd;
        logic [3:0]    alu_op;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
        logic          mem_to_reg;
    } ex_t;

    ex_t           r_ex;
    ex_t           w_load;
    logic [15:0]   r_cnt;
    logic          w_match;
    logic          w_det;

    // Shifts feed amount on A and value on B; variable amounts use only rs[4:0].
    always_comb begin
        w_load            = '0;
        w_load.valid      = bus.id_valid;
        w_load.pc         = bus.id_pc;
        w_load.store_data = bus.id_rt_data;
        w_load.rd         = bus.id_rd;
        w_load.alu_op     = bus.id_alu_op;
        w_load.mem_read   = bus.id_mem_read   & bus.id_valid;
        w_load.mem_write  = bus.id_mem_write  & bus.id_valid;
        w_load.reg_write  = bus.id_reg_write  & bus.id_valid;
        w_load.mem_to_reg = bus.id_mem_to_reg & bus.id_valid;
        if (bus.id_is_shift) begin
            w_load.alu_a = bus.id_shift_var ? DW'(bus.id_rs_data[4:0]) : DW'(bus.id_shamt);
            w_load.alu_b = bus.id_rt_data;
        end else begin
            w_load.alu_a = bus.id_rs_data;
            w_load.alu_b = bus.id_alu_src_imm ? bus.id_imm : bus.id_rt_data;
        end
    end

    // Both sources are compared regardless of whether the instruction reads rt.
    assign w_match = (r_ex.rd == bus.id_rs) | (r_ex.rd == bus.id_rt);
    assign w_det   = HD_EN & r_ex.valid & r_ex.mem_read & (r_ex.rd != '0)
                   & bus.id_valid & w_match;
    assign hazard_stall = w_det & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_ex <= '0;
        end else if (stall_ext) begin
            r_ex <= r_ex;
        end else if (w_det) begin
            r_ex <= '0;
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end else begin
            r_ex <= w_load;
        end
    end

    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_pc         = r_ex.pc;
    assign bus.ex_alu_a      = r_ex.alu_a;
    assign bus.ex_alu_b      = r_ex.alu_b;
    assign bus.ex_store_data = r_ex.store_data;
    assign bus.ex_rd         = r_ex.rd;
    assign bus.ex_alu_op     = r_ex.alu_op;
    assign bus.ex_mem_read   = r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.mem_write;
    assign bus.ex_reg_write  = r_ex.reg_write;
    assign bus.ex_mem_to_reg = r_ex.mem_to_reg;
    assign hazard_cnt        = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed plan steps then random traffic against a behavioural model.
module tb_id_ex_stage;
`ifdef HAZARD_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_ext, flush;
    logic        hazard_stall;
    logic [15:0] hazard_cnt;
    int          checks = 0;
    int          failures = 0;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stall_ext(stall_ext),
        .flush(flush), .hazard_stall(hazard_stall), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        valid;
        bit [31:0] pc, a, b, sd;
        bit [4:0]  rd;
        bit [3:0]  op;
        bit        mr, mw, rw, m2r;
        int        cnt;
    } mdl_t;

    mdl_t m, snap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out();
        chk("ex_valid", bus.ex_valid, m.valid);
        chk("ex_pc", bus.ex_pc, m.pc);
        chk("ex_alu_a", bus.ex_alu_a, m.a);
        chk("ex_alu_b", bus.ex_alu_b, m.b);
        chk("ex_store_data", bus.ex_store_data, m.sd);
        chk("ex_rd", bus.ex_rd, m.rd);
        chk("ex_alu_op", bus.ex_alu_op, m.op);
        chk("ex_mem_read", bus.ex_mem_read, m.mr);
        chk("ex_mem_write", bus.ex_mem_write, m.mw);
        chk("ex_reg_write", bus.ex_reg_write, m.rw);
        chk("ex_mem_to_reg", bus.ex_mem_to_reg, m.m2r);
        chk("hazard_cnt", hazard_cnt, m.cnt);
    endtask

    function automatic bit m_det();
        return HD && m.valid && m.mr && m.rd != 0 && bus.id_valid
            && (m.rd == bus.id_rs || m.rd == bus.id_rt);
    endfunction

    function automatic mdl_t m_bubble(input mdl_t cur);
        mdl_t r = '{default: 0};
        r.cnt = cur.cnt;
        return r;
    endfunction

    // Inputs are already driven; checks hazard_stall, advances model and DUT one edge.
    task automatic step();
        bit   det;
        mdl_t nx;
        #1;
        det = m_det();
        chk("hazard_stall", hazard_stall, det && !flush);
        nx = m;
        if (!rst_n) nx = '{default: 0};
        else if (flush) nx = m_bubble(m);
        else if (stall_ext) nx = m;
        else if (det) begin
            nx = m_bubble(m);
            nx.cnt = (m.cnt >= 65535) ? 65535 : m.cnt + 1;
        end else begin
            nx.valid = bus.id_valid;
            nx.pc = bus.id_pc;
            nx.sd = bus.id_rt_data;
            nx.rd = bus.id_rd;
            nx.op = bus.id_alu_op;
            nx.mr = bus.id_mem_read && bus.id_valid;
            nx.mw = bus.id_mem_write && bus.id_valid;
            nx.rw = bus.id_reg_write && bus.id_valid;
            nx.m2r = bus.id_mem_to_reg && bus.id_valid;
            if (bus.id_is_shift) begin
                nx.a = bus.id_shift_var ? bus.id_rs_data % 32 : 32'(bus.id_shamt);
                nx.b = bus.id_rt_data;
            end else begin
                nx.a = bus.id_rs_data;
                nx.b = bus.id_alu_src_imm ? bus.id_imm : bus.id_rt_data;
            end
        end
        m = nx;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic set_nop();
        rst_n = 1'b1; stall_ext = 1'b0; flush = 1'b0;
        bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_rs_data = '0; bus.id_rt_data = '0;
        bus.id_imm = '0; bus.id_shamt = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_alu_op = '0; bus.id_alu_src_imm = 1'b0; bus.id_is_shift = 1'b0;
        bus.id_shift_var = 1'b0; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
        bus.id_reg_write = 1'b0; bus.id_mem_to_reg = 1'b0;
    endtask

    task automatic set_rand();
        rst_n = ($urandom_range(0, 63) != 0);
        flush = ($urandom_range(0, 15) == 0);
        stall_ext = ($urandom_range(0, 7) == 0);
        bus.id_valid = ($urandom_range(0, 7) != 0);
        bus.id_pc = $urandom; bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
        bus.id_imm = $urandom; bus.id_shamt = 5'($urandom);
        bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
        bus.id_rd = 5'($urandom_range(0, 3)); bus.id_alu_op = 4'($urandom);
        bus.id_alu_src_imm = 1'($urandom); bus.id_is_shift = ($urandom_range(0, 3) == 0);
        bus.id_shift_var = 1'($urandom); bus.id_mem_read = 1'($urandom);
        bus.id_mem_write = 1'($urandom); bus.id_reg_write = 1'($urandom);
        bus.id_mem_to_reg = 1'($urandom);
    endtask

    task automatic set_load(input logic [4:0] rd);
        set_nop();
        bus.id_valid = 1'b1; bus.id_rd = rd; bus.id_mem_read = 1'b1;
        bus.id_reg_write = 1'b1; bus.id_mem_to_reg = 1'b1; bus.id_alu_src_imm = 1'b1;
        bus.id_rs = 5'd29; bus.id_rs_data = 32'h1000; bus.id_imm = 32'h10;
    endtask

    initial begin
        int cnt0;
        set_nop();
        rst_n = 1'b0;
        @(posedge clk); #1;
        m = '{default: 0};
        check_out();

        // Shift by immediate
        set_nop();
        bus.id_valid = 1'b1; bus.id_is_shift = 1'b1; bus.id_shamt = 5'd4;
        bus.id_rt_data = 32'hF000_0000; bus.id_rs_data = 32'hDEAD_BEEF; bus.id_rd = 5'd3;
        step();
        chk("shamt_a", bus.ex_alu_a, 32'h4);
        chk("shamt_b", bus.ex_alu_b, 32'hF000_0000);
        chk("shamt_valid", bus.ex_valid, 1'b1);

        // Variable shift keeps only rs[4:0]
        bus.id_shift_var = 1'b1; bus.id_rs_data = 32'hFFFF_FF25; bus.id_rt_data = 32'h8000_0000;
        step();
        chk("varshift_a", bus.ex_alu_a, 32'h5);
        chk("varshift_b", bus.ex_alu_b, 32'h8000_0000);

        // Load-use on rs
        set_load(5'd8);
        step();
        cnt0 = hazard_cnt;
        set_nop();
        bus.id_valid = 1'b1; bus.id_rs = 5'd8; bus.id_rt = 5'd9; bus.id_rd = 5'd10;
        bus.id_rs_data = 32'h1234_5678; bus.id_rt_data = 32'h9; bus.id_reg_write = 1'b1;
        #1;
        chk("loaduse_stall", hazard_stall, HD);
        step();
        chk("loaduse_bubble", bus.ex_valid, !HD);
        chk("loaduse_cnt", hazard_cnt, cnt0 + (HD ? 1 : 0));
        if (HD) step();
        chk("loaduse_dep_a", bus.ex_alu_a, 32'h1234_5678);
        chk("loaduse_dep_rd", bus.ex_rd, 5'd10);
        chk("loaduse_mr_clear", bus.ex_mem_read, 1'b0);

        // rd=0 load never stalls
        set_load(5'd0);
        step();
        set_nop();
        bus.id_valid = 1'b1; bus.id_rs = 5'd0; bus.id_rd = 5'd4;
        #1;
        chk("rd0_stall", hazard_stall, 1'b0);
        step();
        chk("rd0_valid", bus.ex_valid, 1'b1);

        // flush beats stall_ext
        flush = 1'b1; stall_ext = 1'b1;
        step();
        chk("flush_stall_valid", bus.ex_valid, 1'b0);

        // stall_ext holds three cycles
        set_nop();
        bus.id_valid = 1'b1; bus.id_pc = 32'h400; bus.id_rs_data = 32'hAA; bus.id_rd = 5'd7;
        bus.id_reg_write = 1'b1;
        step();
        snap = m;
        stall_ext = 1'b1; bus.id_pc = 32'h800; bus.id_rs_data = 32'hBB;
        for (int i = 0; i < 3; i++) step();
        chk("hold_pc", bus.ex_pc, 32'h400);
        chk("hold_a", bus.ex_alu_a, 32'hAA);
        chk("hold_valid", bus.ex_valid, snap.valid);

        for (int i = 0; i < 3000; i++) begin
            set_rand();
            step();
        end

`ifdef HAZARD_DETECT_EN
        // Saturation: lw r8 that reads r8, alternating load/bubble
        set_nop();
        rst_n = 1'b0;
        step();
        set_load(5'd8);
        bus.id_rs = 5'd8;
        for (int i = 0; i < 2 * 65536 + 2; i++) step();
        chk("sat_cnt", hazard_cnt, 16'hFFFF);
        if (!bus.ex_valid) step();
        chk("sat_valid", bus.ex_valid, 1'b1);
`else
        set_load(5'd8);
        step();
        chk("pre_rst_valid", bus.ex_valid, 1'b1);
`endif
        set_nop();
        bus.id_valid = 1'b1; bus.id_rs = 5'd8;
        rst_n = 1'b0;
        step();
        chk("rst_valid", bus.ex_valid, 1'b0);
        chk("rst_cnt", hazard_cnt, 16'h0);
        chk("rst_rd", bus.ex_rd, 5'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_stall", hazard_stall, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register of the 5-stage CPU, directly upstream of the ALU and its shifter units. Each cycle it captures one decoded instruction and forms the two ALU operands. For shifts, operand A carries the shift amount and operand B carries the value to be shifted, so the shifter computes `B >> A`. The block also detects load-use hazards, inserts one-cycle bubbles, and supports external hold and flush.

## Interface
Parameters:
- DW, 32, datapath width
- RW, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  DW  PC of decoded instruction
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  pre-extended immediate
- id_shamt  in  5  instruction shamt field
- id_rs, id_rt, id_rd  in  RW  source and destination register numbers (id_rd is the final destination already chosen by decode)
- id_alu_op  in  4  ALU function select
- id_alu_src_imm  in  1  operand B = immediate
- id_is_shift  in  1  instruction is a shift
- id_shift_var  in  1  shift amount comes from rs (srlv/sllv/srav)
- id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1  control bits
- stall_ext  in  1  downstream hold
- flush  in  1  kill the ID/EX slot
- ex_valid  out  1  registered valid
- ex_pc  out  DW  registered PC
- ex_alu_a, ex_alu_b  out  DW  registered ALU operands
- ex_store_data  out  DW  registered rt data
- ex_rd  out  RW  registered destination
- ex_alu_op  out  4  registered ALU function select
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered control bits
- hazard_stall  out  1  combinational; IF and IF/ID must hold this cycle
- hazard_cnt  out  16  saturating count of hazard bubbles

## Operation
Operand formation, evaluated on the id_* inputs:
- Shift with id_shift_var=1: alu_a = {27'b0, id_rs_data[4:0]}, alu_b = id_rt_data. Upper rs bits are masked, so rs=0x00000025 gives a shift of 5.
- Shift with id_shift_var=0: alu_a = {27'b0, id_shamt}, alu_b = id_rt_data.
- Non-shift: alu_a = id_rs_data; alu_b = id_alu_src_imm ? id_imm : id_rt_data.
- store_data = id_rt_data in all cases.

Hazard detect (det) is asserted when all of these hold:
- ex_valid & ex_mem_read & ex_rd≠0
- id_valid
- ex_rd==id_rs or ex_rd==id_rt

The compare is conservative: both sources are checked for every instruction.

Outputs from the detector:
- hazard_stall = det & ~flush.

Register update at each rising edge, in priority order:
1. !rst_n: all ex_* outputs = 0 and hazard_cnt = 0.
2. flush: bubble. ex_valid and all control outputs = 0; data fields hold don't-care (implemented as 0). flush overrides stall_ext.
3. stall_ext: all ex_* hold their values.
4. det: bubble as in 2; hazard_cnt increments.
5. Otherwise: load the formed operands and all id_* fields. ex_valid = id_valid. Control bits are ANDed with id_valid, so an invalid slot never writes.

hazard_cnt:
- Increments only in case 4.
- Saturates at 0xFFFF.
- Does not count while stall_ext or flush is active.

## Timing
- Latency: 1 cycle from id_* inputs to ex_* outputs.
- All ex_* outputs are registered. hazard_stall is combinational from the ex_* registers and the id_* inputs.
- A load-use hazard costs exactly one bubble. After the bubble, ex_mem_read=0 and the held instruction loads on the next edge.
- det together with stall_ext: the register holds (case 3) and no bubble or count is taken. hazard_stall still asserts, which is harmless because upstream is held anyway.
- Reset mid-stream: the first edge with rst_n=0 clears everything. hazard_stall is 0 once the registers clear, because ex_valid=0.

## Configuration
- HAZARD_DETECT_EN defined: behaviour as above.
- HAZARD_DETECT_EN undefined:
  - det is tied 0, so hazard_stall=0 and hazard_cnt stays 0.
  - Load-use protection is the compiler's responsibility.
  - Priority reduces to reset > flush > stall_ext > load.

## Test plan
- Shift by immediate: id_is_shift=1, id_shift_var=0, id_shamt=4, rt=0xF0000000 -> next cycle ex_alu_a=0x00000004, ex_alu_b=0xF0000000, ex_valid=1.
- Variable shift mask: id_shift_var=1, rs=0xFFFFFF25, rt=0x80000000 -> ex_alu_a=0x00000005.
- Load-use: lw to rd=8 in EX; next instruction has id_rs=8 -> hazard_stall=1 for one cycle, ex_valid=0 bubble, hazard_cnt 0->1; dependent instruction in EX one cycle later.
- rd=0 load: lw with ex_rd=0, id_rs=0 -> hazard_stall=0, no bubble.
- Priority: flush=1 and stall_ext=1 together with a valid slot -> ex_valid=0 next cycle. stall_ext=1 alone for 3 cycles -> ex_* unchanged.
- Reset: rst_n=0 for one edge while ex_valid=1 and hazard_cnt=0xFFFF -> all outputs 0, hazard_cnt=0. Separately, force 0x10000 hazards -> hazard_cnt holds at 0xFFFF.
